// File: rtl/mult_div_unit_if.sv
// Request/response bundle for mult_div_unit: the requester drives operands and
// controls, and the unit returns status and results.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             abort;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_by_zero;

    modport master (
        output start, op, a, b, abort,
        input  busy, done, hi, lo, div_by_zero
    );

    modport slave (
        input  start, op, a, b, abort,
        output busy, done, hi, lo, div_by_zero
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative signed/unsigned multiply/divide with fixed WIDTH+1 cycle latency.
// Divide support is compiled in only when MULT_DIV_DIV_EN is defined.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input logic            clk,
    input logic            rst_n,
    mult_div_unit_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             is_div;
    logic             sign_a;
    logic             sign_b;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] lo_r;
`ifdef MULT_DIV_DIV_EN
    logic             dbz_r;
`endif

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + WIDTH'(1)) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v, input logic neg);
        return neg ? (~v + (2*WIDTH)'(1)) : v;
    endfunction

    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic                    in_sa;
    logic                    in_sb;
    assign a_s   = bus.a;
    assign b_s   = bus.b;
    assign in_sa = bus.op[0] && (a_s < 0);
    assign in_sb = bus.op[0] && (b_s < 0);

    // Multiply step: acc:lo_r shifts right one bit, adding the multiplicand when lo_r[0] is set.
    logic [WIDTH:0] mul_sum;
    assign mul_sum = {1'b0, acc} + (lo_r[0] ? {1'b0, mag_b} : {(WIDTH+1){1'b0}});

`ifdef MULT_DIV_DIV_EN
    // Restoring divide step: bit WIDTH of the shifted partial remainder forces a subtract.
    logic [WIDTH:0] div_shift;
    logic [WIDTH:0] div_diff;
    logic           div_ge;
    assign div_shift = {acc, lo_r[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, mag_b};
    assign div_ge    = div_shift[WIDTH] | ~div_diff[WIDTH];
`endif

    logic [2*WIDTH-1:0] prod_fix;
    assign prod_fix = cond_neg2({acc, lo_r}, sign_a ^ sign_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            cnt             <= '0;
            is_div          <= 1'b0;
            sign_a          <= 1'b0;
            sign_b          <= 1'b0;
            mag_b           <= '0;
            acc             <= '0;
            lo_r            <= '0;
`ifdef MULT_DIV_DIV_EN
            dbz_r           <= 1'b0;
`endif
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.div_by_zero <= 1'b0;
            bus.hi          <= '0;
            bus.lo          <= '0;
        end else begin
            bus.done        <= 1'b0;
            bus.div_by_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && !bus.abort) begin
                        is_div   <= bus.op[1];
                        sign_a   <= in_sa;
                        sign_b   <= in_sb;
                        mag_b    <= cond_neg(bus.b, in_sb);
                        lo_r     <= cond_neg(bus.a, in_sa);
                        acc      <= '0;
                        cnt      <= '0;
`ifdef MULT_DIV_DIV_EN
                        dbz_r    <= bus.op[1] && (bus.b == '0);
`endif
                        bus.busy <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (bus.abort) begin
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end else begin
`ifdef MULT_DIV_DIV_EN
                        if (is_div) begin
                            acc  <= div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                            lo_r <= {lo_r[WIDTH-2:0], div_ge};
                        end else
`endif
                        begin
                            acc  <= mul_sum[WIDTH:1];
                            lo_r <= {mul_sum[0], lo_r[WIDTH-1:1]};
                        end
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(WIDTH - 1)) state <= FIX;
                    end
                end
                FIX: begin
                    if (!bus.abort) begin
                        if (is_div) begin
`ifdef MULT_DIV_DIV_EN
                            // Remainder takes the dividend's sign; with b == 0 this restores a.
                            bus.hi          <= cond_neg(acc, sign_a);
                            bus.lo          <= dbz_r ? '1 : cond_neg(lo_r, sign_a ^ sign_b);
                            bus.div_by_zero <= dbz_r;
`else
                            bus.hi          <= '0;
                            bus.lo          <= '0;
`endif
                        end else begin
                            {bus.hi, bus.lo} <= prod_fix;
                        end
                        bus.done <= 1'b1;
                    end
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
